// File: rtl/object_scanner_if.sv
// Result stream of object_scanner toward host/overlay logic.
// Show-ahead valid/ready bundle carrying one kept object per beat.
`ifndef LBL_WIDTH
`define LBL_WIDTH 8
`endif
`ifndef LOC_SIZE
`define LOC_SIZE 10
`endif

interface object_scanner_if #(
  parameter int LBL_W = `LBL_WIDTH,
  parameter int LOC_W = `LOC_SIZE
);
  logic             out_valid;
  logic             out_ready;
  logic [LBL_W-1:0] out_id;
  logic [LOC_W-1:0] out_area;
  logic [LOC_W-1:0] out_x;
  logic [LOC_W-1:0] out_y;

  modport master (
    output out_valid, out_id,
    output out_area, out_x, out_y,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_id,
    input  out_area, out_x, out_y,
    output out_ready
  );
endinterface

// File: rtl/object_scanner.sv
// Post-frame object readout: sweeps labels, filters by area,
// and queues survivors in a show-ahead FIFO.
`ifndef LBL_WIDTH
`define LBL_WIDTH 8
`endif
`ifndef LOC_SIZE
`define LOC_SIZE 10
`endif

module object_scanner #(
  parameter int LBL_W  = `LBL_WIDTH,
  parameter int LOC_W  = `LOC_SIZE,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LBL_W-1:0] num_labels,
  input  logic [LOC_W-1:0] min_area,
  output logic [LBL_W-1:0] obj_id,
  input  logic [LOC_W-1:0] obj_area,
  input  logic [LOC_W-1:0] obj_x,
  input  logic [LOC_W-1:0] obj_y,
  output logic             busy,
  output logic             sweep_done,
  output logic [LBL_W-1:0] kept_count,
  object_scanner_if.master out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);
  localparam logic [2:0] WLOAD = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE, WAIT, CAP, DONE
  } state_t;

  typedef struct packed {
    logic [LBL_W-1:0] id;
    logic [LOC_W-1:0] area;
    logic [LOC_W-1:0] x;
    logic [LOC_W-1:0] y;
  } ent_t;

  state_t           state;
  logic [2:0]       wcnt;
  logic [LBL_W-1:0] last_lbl;

  ent_t             mem [DEPTH];
  ent_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             keep;
  logic             push;
  logic             pop;

  assign full  = count == FULL_N;
  assign empty = count == '0;
  assign keep  = (obj_area >= min_area) &&
                 (obj_area != '0);
  assign push  = (state == CAP) && keep && !full;
  assign pop   = out.out_valid && out.out_ready;

  assign head          = mem[rd_ptr];
  assign out.out_valid = !empty;
  assign out.out_id    = empty ? '0 : head.id;
  assign out.out_area  = empty ? '0 : head.area;
  assign out.out_x     = empty ? '0 : head.x;
  assign out.out_y     = empty ? '0 : head.y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      obj_id     <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      kept_count <= '0;
      wcnt       <= '0;
      last_lbl   <= '0;
    end else begin
      sweep_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_labels == '0) begin
              state      <= DONE;
              sweep_done <= 1'b1;
            end else begin
              last_lbl   <= num_labels;
              obj_id     <= LBL_W'(1);
              kept_count <= '0;
              wcnt       <= WLOAD;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wcnt == '0) state <= CAP;
          else wcnt <= wcnt - 3'd1;
        end
        CAP: begin
          // A kept object facing a full FIFO retries next cycle
          if (!(keep && full)) begin
            if (keep && kept_count != '1)
              kept_count <= kept_count + 1'b1;
            if (obj_id == last_lbl) begin
              state      <= DONE;
              sweep_done <= 1'b1;
            end else begin
              obj_id <= obj_id + 1'b1;
              wcnt   <= WLOAD;
              state  <= WAIT;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{id: obj_id, area: obj_area,
                       x: obj_x, y: obj_y};
  end

endmodule

// File: tb/tb_object_scanner.sv
// Bench for object_scanner: label-stats memory model,
// queue scoreboard on the result stream, randomized sweeps.
module tb_object_scanner;

  localparam int LBL_W  = 8;
  localparam int LOC_W  = 10;
  localparam int RD_LAT = 3;
  localparam int DEPTH  = 4;
  localparam int L      = RD_LAT + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LBL_W-1:0] num_labels;
  logic [LOC_W-1:0] min_area;
  logic [LBL_W-1:0] obj_id;
  logic [LOC_W-1:0] obj_area;
  logic [LOC_W-1:0] obj_x;
  logic [LOC_W-1:0] obj_y;
  logic             busy;
  logic             sweep_done;
  logic [LBL_W-1:0] kept_count;

  object_scanner_if #(.LBL_W(LBL_W), .LOC_W(LOC_W)) oi ();

  object_scanner #(
    .LBL_W(LBL_W), .LOC_W(LOC_W),
    .RD_LAT(RD_LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_labels(num_labels),
    .min_area(min_area),
    .obj_id(obj_id),
    .obj_area(obj_area),
    .obj_x(obj_x),
    .obj_y(obj_y),
    .busy(busy),
    .sweep_done(sweep_done),
    .kept_count(kept_count),
    .out(oi.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  // Label statistics memory with RD_LAT cycles of read latency
  logic [LOC_W-1:0] t_area [256];
  logic [LOC_W-1:0] t_x    [256];
  logic [LOC_W-1:0] t_y    [256];
  logic [LBL_W-1:0] dl     [RD_LAT];

  always @(posedge clk) begin
    dl[0] <= obj_id;
    for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
  end

  assign obj_area = t_area[dl[RD_LAT-1]];
  assign obj_x    = t_x[dl[RD_LAT-1]];
  assign obj_y    = t_y[dl[RD_LAT-1]];

  typedef struct {
    int id;
    int area;
    int x;
    int y;
  } ent_t;

  ent_t expq[$];
  ent_t sb_e;

  always @(negedge clk) begin
    if (!reset && oi.out_valid && oi.out_ready) begin
      if (expq.size() == 0) begin
        check("pop_unexpected", 1, 0);
      end else begin
        sb_e = expq.pop_front();
        check("out_id", oi.out_id, sb_e.id);
        check("out_area", oi.out_area, sb_e.area);
        check("out_x", oi.out_x, sb_e.x);
        check("out_y", oi.out_y, sb_e.y);
      end
    end
  end

  task automatic fill_tab(input int n, input int lo,
                          input int hi);
    for (int k = 1; k <= n; k++) begin
      t_area[k] = LOC_W'($urandom_range(hi, lo));
      t_x[k]    = LOC_W'($urandom_range(1023, 0));
      t_y[k]    = LOC_W'($urandom_range(1023, 0));
    end
  endtask

  function automatic int model(input int n);
    int kept = 0;
    for (int k = 1; k <= n; k++) begin
      if (t_area[k] >= min_area && t_area[k] != 0) begin
        expq.push_back('{k, int'(t_area[k]),
                         int'(t_x[k]), int'(t_y[k])});
        kept++;
      end
    end
    return kept;
  endfunction

  task automatic start_pulse(input int n);
    @(posedge clk); #1;
    num_labels = LBL_W'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic timed_sweep(input int n, input bit extra,
                             input int kept);
    int done_at;
    done_at = 1 + n * L;
    start_pulse(n);
    for (int j = 1; j <= done_at + 1; j++) begin
      @(negedge clk);
      check("obj_id_t",
            obj_id, (j <= n * L) ? 1 + (j - 1) / L : n);
      check("sweep_done_t", sweep_done, j == done_at);
      check("busy_t", busy, j <= done_at);
      @(posedge clk); #1;
      start = extra && (j == 5);
    end
    start = 1'b0;
    check("kept_t", kept_count, kept);
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (rnd) oi.out_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (sweep_done) seen = 1'b1;
    end
    check("sweep_done_seen", seen, 1);
  endtask

  task automatic drain();
    oi.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (expq.size() == 0 && !oi.out_valid) break;
    end
    check("drain_q", expq.size(), 0);
    check("drain_valid", oi.out_valid, 0);
  endtask

  initial begin
    int kept;
    int n;
    for (int k = 0; k < 256; k++) begin
      t_area[k] = '0;
      t_x[k]    = '0;
      t_y[k]    = '0;
    end
    reset = 1'b1;
    start = 1'b0;
    num_labels = '0;
    min_area = '0;
    oi.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_obj_id", obj_id, 0);
    check("rst_valid", oi.out_valid, 0);
    check("rst_kept", kept_count, 0);
    check("rst_done", sweep_done, 0);
    check("rst_out_id", oi.out_id, 0);

    // Directed filter case: areas {5,0,12,3}, min 4
    oi.out_ready = 1'b1;
    min_area = 10'd4;
    fill_tab(4, 0, 0);
    t_area[1] = 10'd5;
    t_area[2] = 10'd0;
    t_area[3] = 10'd12;
    t_area[4] = 10'd3;
    kept = model(4);
    check("model_kept", kept, 2);
    timed_sweep(4, 1'b0, 2);

    // Empty frame: immediate done, nothing changes
    start_pulse(0);
    @(negedge clk);
    check("z_done", sweep_done, 1);
    check("z_busy", busy, 1);
    check("z_obj_id", obj_id, 4);
    check("z_kept", kept_count, 2);
    @(negedge clk);
    check("z_done_low", sweep_done, 0);
    check("z_busy_low", busy, 0);
    check("z_valid", oi.out_valid, 0);

    // Two labels with a spurious start mid-sweep
    min_area = 10'd1;
    fill_tab(2, 1, 1023);
    kept = model(2);
    timed_sweep(2, 1'b1, kept);
    drain();

    // Backpressure: six kept objects into a 4-deep FIFO
    oi.out_ready = 1'b0;
    fill_tab(6, 1, 1023);
    kept = model(6);
    start_pulse(6);
    repeat (6 * L + 4) @(posedge clk);
    @(negedge clk);
    check("stall_busy", busy, 1);
    check("stall_obj_id", obj_id, 5);
    check("stall_valid", oi.out_valid, 1);
    check("stall_head", oi.out_id, 1);
    @(posedge clk); #1 oi.out_ready = 1'b1;
    @(posedge clk); #1 oi.out_ready = 1'b0;
    @(negedge clk);
    check("retry_hold", obj_id, 5);
    @(negedge clk);
    check("retry_adv", obj_id, 6);
    check("retry_head", oi.out_id, 2);
    oi.out_ready = 1'b1;
    wait_done(200, 1'b0);
    check("stall_kept", kept_count, kept);
    drain();

    // Randomized sweeps with random backpressure
    for (int r = 0; r < 25; r++) begin
      n = int'($urandom_range(12, 1));
      min_area = LOC_W'($urandom_range(12, 0));
      fill_tab(n, 0, 15);
      kept = model(n);
      start_pulse(n);
      wait_done(2000, 1'b1);
      check("rnd_kept", kept_count, kept);
    end
    drain();

    // Reset in the middle of a stalled-free sweep
    oi.out_ready = 1'b0;
    min_area = 10'd1;
    fill_tab(6, 1, 1023);
    kept = model(6);
    start_pulse(6);
    repeat (3 * L) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    expq.delete();
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_obj_id", obj_id, 0);
    check("mrst_valid", oi.out_valid, 0);
    check("mrst_kept", kept_count, 0);
    for (int i = 0; i < 8; i++) begin
      check("mrst_no_done", sweep_done, 0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/object_scanner.md
# object_scanner

Post-frame object readout stage downstream of the top-level pixel pipeline. After each frame it sweeps `obj_id` over every connected-component label, waits out the label-statistics read latency, and filters objects by minimum area. Surviving objects' area and location go into an internal FIFO, which is drained by a valid/ready handshake toward the host/overlay logic.

## Interface
Parameters:
- `LBL_W`, default `` `LBL_WIDTH ``: label/object-id width.
- `LOC_W`, default `` `LOC_SIZE ``: area and coordinate width.
- `RD_LAT`, default 1: cycles from `obj_id` change to valid `obj_area/obj_x/obj_y`; legal 1..7.
- `DEPTH`, default 16: result FIFO entries, power of two.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous active-high reset.
- `start`, in, 1: end-of-frame pulse; begins a sweep when idle.
- `num_labels`, in, LBL_W: labels allocated this frame; label 0 is background.
- `min_area`, in, LOC_W: area filter; objects with area < `min_area` are discarded.
- `obj_id`, out, LBL_W: label being read from connected-components statistics.
- `obj_area`, in, LOC_W: statistics of `obj_id`, delayed by `RD_LAT`.
- `obj_x`, in, LOC_W: statistics of `obj_id`, delayed by `RD_LAT`.
- `obj_y`, in, LOC_W: statistics of `obj_id`, delayed by `RD_LAT`.
- `busy`, out, 1: sweep in progress (state ≠ IDLE).
- `sweep_done`, out, 1: one-cycle pulse when the sweep completes.
- `kept_count`, out, LBL_W: objects pushed in the current/last sweep.
- `out_valid`, out, 1: FIFO head valid.
- `out_ready`, in, 1: consumer accepts head.
- `out_id`, out, LBL_W: head entry label.
- `out_area`, out, LOC_W: head entry area.
- `out_x`, out, LOC_W: head entry x.
- `out_y`, out, LOC_W: head entry y.

## Operation
- States: IDLE, WAIT, CAP, DONE.
- IDLE:
  - On `start` with `num_labels` = 0: go to DONE, leaving `obj_id` and `kept_count` unchanged.
  - On `start` with `num_labels` ≠ 0: latch `num_labels` into `last_lbl`, set `obj_id` ← 1, `kept_count` ← 0, `wcnt` ← `RD_LAT`−1, and go to WAIT.
- WAIT: if `wcnt` = 0, go to CAP; otherwise decrement `wcnt`.
- CAP: sample `obj_area/x/y`.
  - Keep the object if `obj_area` ≥ `min_area` and `obj_area` ≠ 0.
  - If kept and the FIFO is full, stay in CAP, holding `obj_id` (stall; no drop).
  - Otherwise push `{obj_id, area, x, y}` if kept and increment `kept_count` (saturating at all-ones).
  - Then, if `obj_id` = `last_lbl`, go to DONE; else `obj_id` ← `obj_id`+1, `wcnt` ← `RD_LAT`−1, WAIT.
- DONE: assert `sweep_done` for one cycle, then go to IDLE. `obj_id` holds its last value.
- `start` while `busy` is ignored. `num_labels`/`min_area` changes mid-sweep: `num_labels` has no effect (latched); `min_area` is used live.
- FIFO:
  - Show-ahead: `out_*` reflect the head whenever `out_valid` = 1.
  - Pop on `out_valid & out_ready`.
  - Push is blocked when full even if a pop occurs in the same cycle. A pop then frees the slot and the CAP retry succeeds on the next cycle.
  - Push and pop on a non-full, non-empty FIFO occur together; occupancy is unchanged.
  - Pointers wrap modulo `DEPTH`; a separate occupancy counter (log2(DEPTH)+1 bits) distinguishes full from empty.
- The FIFO is not cleared by `start`; entries from earlier sweeps drain in order.

## Timing
- Reset, synchronous, takes priority over everything including an in-progress sweep:
  - state IDLE, `obj_id` = 0, `busy` = 0, `sweep_done` = 0, `kept_count` = 0;
  - FIFO emptied, `out_valid` = 0, `out_id/area/x/y` = 0.
- All outputs are registered except `out_*`, which are a FIFO read with registered pointers.
- `start` sampled at edge t: `busy` = 1 and `obj_id` = 1 from t+1.
- Each label occupies `RD_LAT`+1 cycles absent stalls. The CAP decision at the edge ending cycle t+1+`RD_LAT`+k(`RD_LAT`+1) handles label k+1.
- N labels with no stalls: `sweep_done` is high in cycle t+1+N(`RD_LAT`+1); `busy` falls the next cycle.
- Push latency: an entry written at edge e gives `out_valid` = 1 in the cycle after e.
- A stall extends the sweep by one cycle per full cycle.

## Test plan
- Reset mid-sweep (after 3 labels, FIFO holding 2): next cycle `busy` = 0, `obj_id` = 0, `out_valid` = 0, `kept_count` = 0, and no `sweep_done`.
- `RD_LAT`=1, `num_labels`=4, areas {5,0,12,3}, `min_area`=4, `out_ready`=1:
  - FIFO yields ids 1 then 3 with their area/x/y;
  - `kept_count` = 2;
  - `sweep_done` 9 cycles after `start`.
- `num_labels`=0 with `start`: `sweep_done` pulses 1 cycle later; `kept_count` and `obj_id` unchanged; no push.
- `DEPTH`=4, `num_labels`=6, all areas ≥ `min_area`, `out_ready`=0:
  - sweep stalls at `obj_id`=5, `busy` stays 1.
  - Raising `out_ready` for one cycle pops id 1; id 5 is pushed on the following cycle.
  - Sweep completes with ids 2..6 delivered in order.
- `RD_LAT`=3, `num_labels`=2: `obj_id` holds each value 4 cycles; the captured values are those presented 3 cycles after the `obj_id` change. A second `start` pulse mid-sweep has no effect.
- Same-cycle push and pop with occupancy 2: occupancy stays 2 and ordering is preserved.
